// File: rtl/inst_mem_sync_if.sv
// Instruction-fetch bus between the CPU fetch stage (master) and the
// instruction memory (slave). Request side: ce/addr/flush. Response side: inst/valid/err.
interface inst_mem_sync_if;
    logic        inst_mem_ce;
    logic [31:0] addr;
    logic        flush;
    logic        req_ready;
    logic [31:0] inst;
    logic        inst_valid;
    logic        inst_err;

    modport master (
        output inst_mem_ce, addr, flush,
        input  req_ready, inst, inst_valid, inst_err
    );

    modport slave (
        input  inst_mem_ce, addr, flush,
        output req_ready, inst, inst_valid, inst_err
    );
endinterface

// File: rtl/inst_mem_sync.sv
// Registered instruction memory with programmable wait states. It accepts one
// fetch at a time, answers with a one-cycle valid strobe, and has a preload port.
module inst_mem_sync #(
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    inst_mem_sync_if.slave        bus,
    input  logic                  load_we,
    input  logic [DEPTH_LOG2-1:0] load_addr,
    input  logic [31:0]           load_data
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t                state_reg, state_next;
    logic [3:0]            cnt_reg, cnt_next;
    logic [DEPTH_LOG2-1:0] idx_reg;
    logic                  err_lat_reg;
    logic [DEPTH_LOG2-1:0] acc_idx, fetch_idx;
    logic                  acc_err, fetch_err;
    logic                  accept;
    logic                  rd_en;

    logic [31:0]           mem [DEPTH];
    logic [31:0]           rd_data_reg;
    logic                  resp_err_reg;
    logic                  resp_loaded_reg;

    assign acc_idx = bus.addr[DEPTH_LOG2+1:2];
    assign acc_err = (bus.addr[1:0] != 2'b00) || (bus.addr[31:DEPTH_LOG2+2] != '0);

    // Without wait states the array is read on the accept edge itself, so the
    // live address is used; otherwise the copy latched at accept is used.
    assign fetch_idx = (WAIT_CYCLES == 0) ? acc_idx : idx_reg;
    assign fetch_err = (WAIT_CYCLES == 0) ? acc_err : err_lat_reg;

    assign bus.req_ready  = (state_reg != ST_WAIT);
    assign bus.inst_valid = (state_reg == ST_RESP);
    assign accept         = bus.inst_mem_ce && bus.req_ready && !bus.flush;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        rd_en      = 1'b0;
        if (bus.flush) begin
            state_next = ST_IDLE;
            cnt_next   = 4'd0;
        end else begin
            case (state_reg)
                ST_IDLE, ST_RESP: begin
                    if (accept) begin
                        if (WAIT_CYCLES == 0) begin
                            state_next = ST_RESP;
                            rd_en      = 1'b1;
                        end else begin
                            state_next = ST_WAIT;
                            cnt_next   = WAIT_LOAD;
                        end
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (cnt_reg == 4'd0) begin
                        state_next = ST_RESP;
                        rd_en      = 1'b1;
                    end else begin
                        cnt_next = cnt_reg - 4'd1;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg       <= ST_IDLE;
            cnt_reg         <= 4'd0;
            idx_reg         <= '0;
            err_lat_reg     <= 1'b0;
            resp_err_reg    <= 1'b0;
            resp_loaded_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (accept) begin
                idx_reg     <= acc_idx;
                err_lat_reg <= acc_err;
            end
            if (rd_en) begin
                resp_err_reg    <= fetch_err;
                resp_loaded_reg <= 1'b1;
            end
        end
    end

    // Array and read register carry no reset so they map onto block RAM;
    // a same-edge load to the fetched word yields the old contents.
    always_ff @(posedge clk) begin
        if (load_we) begin
            mem[load_addr] <= load_data;
        end
        if (rd_en) begin
            rd_data_reg <= mem[fetch_idx];
        end
    end

    // resp_loaded_reg keeps inst at zero after reset until a real response.
    assign bus.inst     = (resp_loaded_reg && !resp_err_reg) ? rd_data_reg : 32'd0;
    assign bus.inst_err = resp_err_reg;

endmodule

// File: tb/tb_inst_mem_sync.sv
// Directed bench for inst_mem_sync: three instances with 0, 3 and 2 wait
// states sharing clock, reset and preload port.
module tb_inst_mem_sync;

    logic        clk;
    logic        rst;
    logic        load_we;
    logic [9:0]  load_addr;
    logic [31:0] load_data;

    int checks   = 0;
    int failures = 0;

    inst_mem_sync_if if0 ();
    inst_mem_sync_if if3 ();
    inst_mem_sync_if if2 ();

    inst_mem_sync #(.DEPTH_LOG2(10), .WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .rst(rst), .bus(if0),
        .load_we(load_we), .load_addr(load_addr), .load_data(load_data)
    );
    inst_mem_sync #(.DEPTH_LOG2(10), .WAIT_CYCLES(3)) u_w3 (
        .clk(clk), .rst(rst), .bus(if3),
        .load_we(load_we), .load_addr(load_addr), .load_data(load_data)
    );
    inst_mem_sync #(.DEPTH_LOG2(10), .WAIT_CYCLES(2)) u_w2 (
        .clk(clk), .rst(rst), .bus(if2),
        .load_we(load_we), .load_addr(load_addr), .load_data(load_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input int idx, input logic [31:0] d);
        load_we   = 1'b1;
        load_addr = 10'(idx);
        load_data = d;
        step();
        load_we   = 1'b0;
    endtask

    initial begin
        if0.inst_mem_ce = 1'b0; if0.addr = 32'd0; if0.flush = 1'b0;
        if3.inst_mem_ce = 1'b0; if3.addr = 32'd0; if3.flush = 1'b0;
        if2.inst_mem_ce = 1'b0; if2.addr = 32'd0; if2.flush = 1'b0;
        load_we = 1'b0; load_addr = 10'd0; load_data = 32'd0;
        rst = 1'b1;
        #1 rst = 1'b0;
        #2;

        chk("reset_req_ready", 32'(if0.req_ready), 32'd1);
        chk("reset_inst_valid", 32'(if0.inst_valid), 32'd0);
        chk("reset_inst", if0.inst, 32'd0);
        chk("reset_inst_err", 32'(if0.inst_err), 32'd0);
        chk("reset_w3_req_ready", 32'(if3.req_ready), 32'd1);

        // Preload while reset is held; the array is independent of reset.
        load_word(0, 32'h3401_0001);
        load_word(1, 32'h3401_0002);
        load_word(2, 32'h3401_0003);
        load_word(3, 32'h3401_0004);
        load_word(4, 32'hDEAD_BEEF);
        load_word(5, 32'h1111_1111);
        load_word(8, 32'hCAFE_F00D);
        rst = 1'b1;
        step();
        chk("idle_valid_after_release", 32'(if0.inst_valid), 32'd0);

        // Back-to-back fetches, no wait states.
        if0.inst_mem_ce = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if0.addr = 32'(4 * i);
            step();
            chk($sformatf("b2b_valid_%0d", i), 32'(if0.inst_valid), 32'd1);
            chk($sformatf("b2b_inst_%0d", i), if0.inst, 32'h3401_0001 + 32'(i));
            chk($sformatf("b2b_ready_%0d", i), 32'(if0.req_ready), 32'd1);
        end
        if0.inst_mem_ce = 1'b0;
        step();
        chk("b2b_valid_end", 32'(if0.inst_valid), 32'd0);

        // Three wait states; addr changes during WAIT must be ignored.
        if3.inst_mem_ce = 1'b1;
        if3.addr = 32'h10;
        step();
        if3.inst_mem_ce = 1'b0;
        if3.addr = 32'h0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("w3_ready_low_%0d", i), 32'(if3.req_ready), 32'd0);
            chk($sformatf("w3_valid_low_%0d", i), 32'(if3.inst_valid), 32'd0);
            step();
        end
        chk("w3_valid", 32'(if3.inst_valid), 32'd1);
        chk("w3_inst", if3.inst, 32'hDEAD_BEEF);
        chk("w3_ready_resp", 32'(if3.req_ready), 32'd1);
        chk("w3_err", 32'(if3.inst_err), 32'd0);
        step();
        chk("w3_valid_drop", 32'(if3.inst_valid), 32'd0);
        chk("w3_inst_hold", if3.inst, 32'hDEAD_BEEF);

        // Misaligned and out-of-range fetches.
        if0.inst_mem_ce = 1'b1;
        if0.addr = 32'h2;
        step();
        chk("misalign_valid", 32'(if0.inst_valid), 32'd1);
        chk("misalign_err", 32'(if0.inst_err), 32'd1);
        chk("misalign_inst", if0.inst, 32'd0);
        if0.addr = 32'h1000;
        step();
        chk("range_valid", 32'(if0.inst_valid), 32'd1);
        chk("range_err", 32'(if0.inst_err), 32'd1);
        chk("range_inst", if0.inst, 32'd0);
        if0.addr = 32'h8;
        step();
        chk("recover_err", 32'(if0.inst_err), 32'd0);
        chk("recover_inst", if0.inst, 32'h3401_0003);
        if0.inst_mem_ce = 1'b0;
        step();

        // Flush in the first WAIT cycle, with a concurrent request.
        if2.inst_mem_ce = 1'b1;
        if2.addr = 32'h4;
        step();
        chk("flush_ready_wait", 32'(if2.req_ready), 32'd0);
        if2.flush = 1'b1;
        if2.addr = 32'h20;
        step();
        if2.flush = 1'b0;
        if2.inst_mem_ce = 1'b0;
        chk("flush_ready_idle", 32'(if2.req_ready), 32'd1);
        chk("flush_valid", 32'(if2.inst_valid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("flush_no_resp_%0d", i), 32'(if2.inst_valid), 32'd0);
        end

        // Read-before-write on the RESP-entry edge.
        if0.inst_mem_ce = 1'b1;
        if0.addr = 32'h14;
        load_we = 1'b1;
        load_addr = 10'd5;
        load_data = 32'h2222_2222;
        step();
        load_we = 1'b0;
        chk("rbw_valid", 32'(if0.inst_valid), 32'd1);
        chk("rbw_old", if0.inst, 32'h1111_1111);
        step();
        chk("rbw_new", if0.inst, 32'h2222_2222);
        if0.inst_mem_ce = 1'b0;
        step();

        // Asynchronous reset in the middle of a WAIT.
        if3.inst_mem_ce = 1'b1;
        if3.addr = 32'hC;
        step();
        if3.inst_mem_ce = 1'b0;
        step();
        chk("rst_pre_ready", 32'(if3.req_ready), 32'd0);
        #2 rst = 1'b0;
        #1;
        chk("rst_async_ready", 32'(if3.req_ready), 32'd1);
        chk("rst_async_valid", 32'(if3.inst_valid), 32'd0);
        chk("rst_async_inst", if3.inst, 32'd0);
        chk("rst_async_err", 32'(if3.inst_err), 32'd0);
        step();
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("rst_dropped_%0d", i), 32'(if3.inst_valid), 32'd0);
        end
        if3.inst_mem_ce = 1'b1;
        if3.addr = 32'h10;
        step();
        if3.inst_mem_ce = 1'b0;
        step();
        step();
        step();
        chk("post_rst_valid", 32'(if3.inst_valid), 32'd1);
        chk("post_rst_contents", if3.inst, 32'hDEAD_BEEF);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
